// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-address sequencer and its target calculator.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_REL = 2'd0,
    JALR   = 2'd1,
    TRAP   = 2'd2,
    RSVD   = 2'd3
  } redirect_kind_e;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } pc_state_e;

  localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target calculator; also flags targets that violate instruction alignment.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(32'h0000_0100),
  parameter int              ALIGN_BITS  = 2
) (
  input  redirect_kind_e  kind,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [XLEN-1:0] BIT0_CLEAR = ~XLEN'(1);

  // Only PC-relative and JALR targets can be misaligned; the trap vector is trusted.
  always_comb begin
    target     = '0;
    misaligned = 1'b0;
    case (kind)
      PC_REL:  target = pc + imm;
      JALR:    target = (rs1 + imm) & BIT0_CLEAR;
      TRAP:    target = TRAP_VECTOR;
      default: target = '0;
    endcase
    if (kind == PC_REL || kind == JALR)
      misaligned = |(target & ALIGN_MASK);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: issues fetch requests over valid/ready, applies redirects with an
// epoch tag, and parks in a fault state on misaligned jump targets until a trap redirect.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              ALIGN_BITS   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_pc,
  output logic            fetch_epoch,
  input  logic            redirect_valid,
  input  logic [1:0]      redirect_kind,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic [XLEN-1:0] redirect_imm,
  input  logic [XLEN-1:0] redirect_rs1,
  output logic            fault,
  output logic [XLEN-1:0] fault_addr
);

  pc_state_e      state;
  redirect_kind_e kind;
  logic [XLEN-1:0] target;
  logic            misaligned;
  logic            handshake;
  logic            take_trap;
  logic            take_jump;

  assign kind      = redirect_kind_e'(redirect_kind);
  assign handshake = fetch_valid & fetch_ready;
  assign take_trap = redirect_valid && (kind == TRAP);
  assign take_jump = redirect_valid && (kind == PC_REL || kind == JALR);

  pc_target_calc #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR),
    .ALIGN_BITS  (ALIGN_BITS)
  ) u_target_calc (
    .kind       (kind),
    .pc         (redirect_pc),
    .imm        (redirect_imm),
    .rs1        (redirect_rs1),
    .target     (target),
    .misaligned (misaligned)
  );

  // Redirects take priority over a same-cycle handshake: memory still consumes the old
  // request, but the increment is dropped and the epoch flip marks its response as stale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      fetch_pc    <= RESET_VECTOR;
      fetch_valid <= 1'b0;
      fetch_epoch <= 1'b0;
      fault       <= 1'b0;
      fault_addr  <= '0;
    end else begin
      case (state)
        BOOT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        RUN: begin
          if (take_trap) begin
            fetch_pc    <= TRAP_VECTOR;
            fetch_epoch <= ~fetch_epoch;
            fetch_valid <= 1'b1;
            fault       <= 1'b0;
          end else if (take_jump && misaligned) begin
            state       <= FAULT;
            fault       <= 1'b1;
            fault_addr  <= target;
            fetch_valid <= 1'b0;
          end else if (take_jump) begin
            fetch_pc    <= target;
            fetch_epoch <= ~fetch_epoch;
            fetch_valid <= 1'b1;
          end else begin
            if (handshake)
              fetch_pc <= fetch_pc + XLEN'(PC_INCR);
            // A pending unaccepted request must not be withdrawn by a stall.
            if (!fetch_valid || fetch_ready)
              fetch_valid <= ~stall;
          end
        end
        FAULT: begin
          fetch_valid <= 1'b0;
          if (take_trap) begin
            state       <= RUN;
            fetch_pc    <= TRAP_VECTOR;
            fetch_epoch <= ~fetch_epoch;
            fetch_valid <= 1'b1;
            fault       <= 1'b0;
          end
        end
        default: begin
          state       <= BOOT;
          fetch_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, reset corner cases, then
// randomized traffic compared against a behavioural model of the fetch rules.
module tb_pc_sequencer;

  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
  localparam logic [31:0] RST_VEC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        fetch_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [1:0]  redirect_kind = 2'd0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] redirect_imm = '0;
  logic [31:0] redirect_rs1 = '0;
  logic        fetch_valid;
  logic        fetch_epoch;
  logic        fault;
  logic [31:0] fetch_pc;
  logic [31:0] fault_addr;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic        stall;
    logic        ready;
    logic        rv;
    logic [1:0]  kind;
    logic [31:0] rpc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        evalid;
    logic [31:0] epc;
    logic        eep;
    logic        efault;
    logic [31:0] efaddr;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state for the random phase
  bit          mBooting;
  bit          mValid;
  bit          mEpoch;
  bit          mFault;
  logic [31:0] mPc;
  logic [31:0] mFaddr;

  pc_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_pc       (fetch_pc),
    .fetch_epoch    (fetch_epoch),
    .redirect_valid (redirect_valid),
    .redirect_kind  (redirect_kind),
    .redirect_pc    (redirect_pc),
    .redirect_imm   (redirect_imm),
    .redirect_rs1   (redirect_rs1),
    .fault          (fault),
    .fault_addr     (fault_addr)
  );

  always #5 clk = ~clk;

  task automatic addVec(input logic s, input logic r, input logic rv, input logic [1:0] k,
                        input logic [31:0] rpc, input logic [31:0] imm, input logic [31:0] rs1,
                        input logic ev, input logic [31:0] epc, input logic eep,
                        input logic ef, input logic [31:0] efa);
    vec_t v;
    v.stall = s; v.ready = r; v.rv = rv; v.kind = k;
    v.rpc = rpc; v.imm = imm; v.rs1 = rs1;
    v.evalid = ev; v.epc = epc; v.eep = eep; v.efault = ef; v.efaddr = efa;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic rv, input logic [1:0] k,
                               input logic [31:0] rpc, input logic [31:0] imm,
                               input logic [31:0] rs1);
    stall          = s;
    fetch_ready    = r;
    redirect_valid = rv;
    redirect_kind  = k;
    redirect_pc    = rpc;
    redirect_imm   = imm;
    redirect_rs1   = rs1;
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [31:0] epc,
                             input logic eep, input logic ef, input logic [31:0] efa);
    cmp({name, ".valid"}, {31'd0, fetch_valid}, {31'd0, ev});
    cmp({name, ".pc"}, fetch_pc, epc);
    cmp({name, ".epoch"}, {31'd0, fetch_epoch}, {31'd0, eep});
    cmp({name, ".fault"}, {31'd0, fault}, {31'd0, ef});
    cmp({name, ".fault_addr"}, fault_addr, efa);
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  // Next-cycle expectations derived from the fetch rules, applied to the inputs now driven.
  task automatic modelStep();
    logic [31:0] tgt;
    if (mBooting) begin
      mBooting = 0;
      mValid   = 1;
    end else if (redirect_valid && redirect_kind == 2'd2) begin
      mPc    = TRAP_VEC;
      mEpoch = !mEpoch;
      mFault = 0;
      mValid = 1;
    end else if (mFault) begin
      mValid = 0;
    end else if (redirect_valid && redirect_kind < 2'd2) begin
      if (redirect_kind == 2'd0) tgt = redirect_pc + redirect_imm;
      else                       tgt = ((redirect_rs1 + redirect_imm) >> 1) << 1;
      if (tgt % 4 != 0) begin
        mFault = 1;
        mFaddr = tgt;
        mValid = 0;
      end else begin
        mPc    = tgt;
        mEpoch = !mEpoch;
        mValid = 1;
      end
    end else begin
      if (mValid && fetch_ready) begin
        mPc    = mPc + 4;
        mValid = !stall;
      end else if (!mValid) begin
        mValid = !stall;
      end
    end
  endtask

  initial begin
    // Directed table: inputs before the edge, expected outputs after it
    addVec(0,1,0,0,0,0,0,                   1,32'h0,0,0,0);
    addVec(0,1,0,0,0,0,0,                   1,32'h4,0,0,0);
    addVec(0,1,0,0,0,0,0,                   1,32'h8,0,0,0);
    addVec(0,0,0,0,0,0,0,                   1,32'h8,0,0,0);
    addVec(1,0,0,0,0,0,0,                   1,32'h8,0,0,0);
    addVec(0,0,0,0,0,0,0,                   1,32'h8,0,0,0);
    addVec(0,1,0,0,0,0,0,                   1,32'hC,0,0,0);
    addVec(0,1,0,0,0,0,0,                   1,32'h10,0,0,0);
    addVec(1,1,0,0,0,0,0,                   0,32'h14,0,0,0);
    addVec(1,1,0,0,0,0,0,                   0,32'h14,0,0,0);
    addVec(0,1,0,0,0,0,0,                   1,32'h14,0,0,0);
    addVec(0,1,1,0,32'h40,32'hFFFF_FFF8,0,  1,32'h38,1,0,0);
    addVec(0,1,0,0,0,0,0,                   1,32'h3C,1,0,0);
    addVec(0,0,1,1,0,32'h10,32'h1001,       1,32'h1010,0,0,0);
    addVec(1,0,0,0,0,0,0,                   1,32'h1010,0,0,0);
    addVec(0,0,1,1,0,0,32'h102,             0,32'h1010,0,1,32'h102);
    addVec(0,1,1,0,0,32'h200,0,             0,32'h1010,0,1,32'h102);
    addVec(0,1,1,3,0,0,0,                   0,32'h1010,0,1,32'h102);
    addVec(0,1,0,0,0,0,0,                   0,32'h1010,0,1,32'h102);
    addVec(0,1,1,2,0,0,0,                   1,32'h100,1,0,32'h102);
    addVec(0,1,0,0,0,0,0,                   1,32'h104,1,0,32'h102);
    addVec(0,1,1,0,32'h10,32'hFFFF_FFEC,0,  1,32'hFFFF_FFFC,0,0,32'h102);
    addVec(0,1,0,0,0,0,0,                   1,32'h0,0,0,32'h102);
    addVec(0,1,0,0,0,0,0,                   1,32'h4,0,0,32'h102);
    addVec(0,1,1,0,32'h200,0,0,             1,32'h200,1,0,32'h102);
    addVec(0,1,1,1,0,32'h4,32'h300,         1,32'h304,0,0,32'h102);
    addVec(0,1,1,3,0,32'h7,0,               1,32'h308,0,0,32'h102);
    addVec(0,1,1,0,32'h10,32'h2,0,          0,32'h308,0,1,32'h12);
    addVec(1,1,1,2,0,0,0,                   1,32'h100,1,0,32'h12);
    addVec(0,1,1,1,0,32'h3,32'h201,         1,32'h204,0,0,32'h12);

    $display("[TB] reset phase");
    stepEdge();
    stepEdge();
    checkOutput("reset", 0, RST_VEC, 0, 0, 32'h0);
    reset = 1'b0;
    #1;
    checkOutput("boot", 0, RST_VEC, 0, 0, 32'h0);

    $display("[TB] directed vectors: %0d rows", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].stall, vecs[i].ready, vecs[i].rv, vecs[i].kind,
                    vecs[i].rpc, vecs[i].imm, vecs[i].rs1);
      stepEdge();
      checkOutput($sformatf("vec%0d", i), vecs[i].evalid, vecs[i].epc, vecs[i].eep,
                  vecs[i].efault, vecs[i].efaddr);
    end

    // Asynchronous reset mid-stream takes effect without a clock edge
    applyStimulus(0,1,0,0,0,0,0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", 0, RST_VEC, 0, 0, 32'h0);
    stepEdge();
    reset = 1'b0;
    #1;
    checkOutput("reboot", 0, RST_VEC, 0, 0, 32'h0);
    stepEdge();
    checkOutput("reboot_run", 1, RST_VEC, 0, 0, 32'h0);

    $display("[TB] random phase");
    mBooting = 0; mValid = 1; mEpoch = 0; mFault = 0; mPc = RST_VEC; mFaddr = '0;
    for (int c = 0; c < 600; c++) begin
      applyStimulus($urandom_range(0, 3) == 0,
                    $urandom_range(0, 2) != 0,
                    $urandom_range(0, 4) == 0,
                    2'($urandom_range(0, 3)),
                    $urandom & 32'hFFFF_FFFC,
                    ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'h0000_FFFC),
                    ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC));
      modelStep();
      stepEdge();
      checkOutput($sformatf("rand%0d", c), mValid, mPc, mEpoch, mFault, mFaddr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
